phy_link_monitor: RTL and testbench

- Downstream consumer of the MDIO controller's read path.
- Paces periodic PHY status reads by raising `poll_req`. Captures each returned 16-bit status word (BMSR layout) and debounces the link bit.
- Publishes a clean link state, change pulses, a saturating link-drop counter and a stale-data flag to the rest of the Ethernet datapath.
- Holds off all polling until the MDIO controller reports PHY setup complete.

---
 rtl/phy_pkg.sv | 22 ++
 rtl/sat_debounce.sv | 48 ++++
 rtl/phy_link_monitor.sv | 115 +++++++++++
 tb/tb_phy_link_monitor.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Shared constants for the PHY link monitor: BMSR bit positions, FSM state
// encoding and the saturating counter helper.
package phy_pkg;

  localparam int unsigned BMSR_LINK   = 2;
  localparam int unsigned BMSR_RFAULT = 4;
  localparam int unsigned BMSR_ANDONE = 5;

  localparam logic [1:0] ST_WAIT_SETUP = 2'd0;
  localparam logic [1:0] ST_WAIT_POLL  = 2'd1;
  localparam logic [1:0] ST_REQ        = 2'd2;
  localparam logic [1:0] ST_EVAL       = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    if (value == 8'hFF) begin
      return 8'hFF;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/sat_debounce.sv
// Link-bit debouncer: counts consecutive samples that disagree with the
// published link state and toggles it once DEBOUNCE of them have been seen.
module sat_debounce
  import phy_pkg::*;
#(
  parameter logic [2:0] DEBOUNCE = 3'd3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       sample_valid,
  input  logic       sample_bit,
  output logic       link_up,
  output logic       link_change,
  output logic [7:0] drop_count
);

  logic [2:0] agree_r;
  logic [2:0] agree_next;

  assign agree_next = agree_r + 3'd1;

  // Agree counter, link state, one-cycle change pulse and saturating drop count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      agree_r     <= 3'd0;
      link_up     <= 1'b0;
      link_change <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      link_change <= 1'b0;
      if (sample_valid) begin
        if (sample_bit == link_up) begin
          agree_r <= 3'd0;
        end else if (agree_next == DEBOUNCE) begin
          agree_r     <= 3'd0;
          link_up     <= ~link_up;
          link_change <= 1'b1;
          if (link_up) begin
            drop_count <= sat_inc8(drop_count);
          end
        end else begin
          agree_r <= agree_next;
        end
      end
    end
  end

endmodule

// File: rtl/phy_link_monitor.sv
// Paces periodic PHY status reads, captures the returned BMSR word and
// publishes debounced link state, fault/AN flags and a stale-data indication.
module phy_link_monitor
  import phy_pkg::*;
#(
  parameter logic [19:0] POLL_PERIOD = 20'd1000000,
  parameter logic [15:0] TIMEOUT     = 16'd50000,
  parameter logic [2:0]  DEBOUNCE    = 3'd3,
  parameter logic [3:0]  LINK_BIT    = 4'(BMSR_LINK)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        mdio_ready,
  input  logic [15:0] rd_data,
  input  logic        rd_valid,
  output logic        poll_req,
  output logic        link_up,
  output logic        an_done,
  output logic        remote_fault,
  output logic        link_change,
  output logic [7:0]  drop_count,
  output logic        stale
);

  localparam logic [19:0] POLL_LAST    = POLL_PERIOD - 20'd1;
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT - 16'd1;

  logic [1:0]  state_r;
  logic [19:0] period_cnt_r;
  logic [15:0] timeout_cnt_r;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_unused;

  // Only the link, fault and AN bits of the captured word are consumed.
  assign sample_unused = ^sample_r;
  assign sample_valid  = (state_r == ST_EVAL) && mdio_ready;

  // Poll FSM; losing mdio_ready takes priority over every state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r       <= ST_WAIT_SETUP;
      period_cnt_r  <= 20'd0;
      timeout_cnt_r <= 16'd0;
      sample_r      <= 16'd0;
      poll_req      <= 1'b0;
      an_done       <= 1'b0;
      remote_fault  <= 1'b0;
      stale         <= 1'b0;
    end else if (!mdio_ready) begin
      state_r       <= ST_WAIT_SETUP;
      period_cnt_r  <= 20'd0;
      timeout_cnt_r <= 16'd0;
      poll_req      <= 1'b0;
    end else begin
      case (state_r)
        ST_WAIT_SETUP: begin
          state_r      <= ST_WAIT_POLL;
          period_cnt_r <= 20'd0;
        end
        ST_WAIT_POLL: begin
          if (period_cnt_r == POLL_LAST) begin
            state_r       <= ST_REQ;
            poll_req      <= 1'b1;
            period_cnt_r  <= 20'd0;
            timeout_cnt_r <= 16'd0;
          end else begin
            period_cnt_r <= period_cnt_r + 20'd1;
          end
        end
        ST_REQ: begin
          // A read returned on the final timeout cycle is still accepted.
          if (rd_valid) begin
            sample_r      <= rd_data;
            poll_req      <= 1'b0;
            timeout_cnt_r <= 16'd0;
            state_r       <= ST_EVAL;
          end else if (timeout_cnt_r == TIMEOUT_LAST) begin
            stale         <= 1'b1;
            poll_req      <= 1'b0;
            timeout_cnt_r <= 16'd0;
            period_cnt_r  <= 20'd0;
            state_r       <= ST_WAIT_POLL;
          end else begin
            timeout_cnt_r <= timeout_cnt_r + 16'd1;
          end
        end
        ST_EVAL: begin
          an_done      <= sample_r[BMSR_ANDONE];
          remote_fault <= sample_r[BMSR_RFAULT];
          stale        <= 1'b0;
          period_cnt_r <= 20'd0;
          state_r      <= ST_WAIT_POLL;
        end
        default: begin
          state_r  <= ST_WAIT_SETUP;
          poll_req <= 1'b0;
        end
      endcase
    end
  end

  sat_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .CLK         (CLK),
    .RST         (RST),
    .sample_valid(sample_valid),
    .sample_bit  (sample_r[LINK_BIT]),
    .link_up     (link_up),
    .link_change (link_change),
    .drop_count  (drop_count)
  );

endmodule

// File: tb/tb_phy_link_monitor.sv
// Self-checking bench for phy_link_monitor: directed scenarios plus randomized
// polls compared against a sample-level behavioural model.
`timescale 1ns/1ps
module tb_phy_link_monitor;

  localparam int DEB = 3;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        mdio_ready = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = 16'd0;
  logic        poll_req, link_up, an_done, remote_fault, link_change, stale;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // Behavioural model state, updated once per accepted status word.
  logic exp_link, exp_an, exp_rf, exp_stale, exp_toggle;
  int   exp_run, exp_drops;

  phy_link_monitor #(
    .POLL_PERIOD(20'd16),
    .TIMEOUT    (16'd8),
    .DEBOUNCE   (3'd3),
    .LINK_BIT   (4'd2)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .mdio_ready  (mdio_ready),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .poll_req    (poll_req),
    .link_up     (link_up),
    .an_done     (an_done),
    .remote_fault(remote_fault),
    .link_change (link_change),
    .drop_count  (drop_count),
    .stale       (stale)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (link_change === 1'b1) pulse_cnt++;

  task automatic model_reset();
    exp_link = 1'b0; exp_an = 1'b0; exp_rf = 1'b0; exp_stale = 1'b0;
    exp_toggle = 1'b0; exp_run = 0; exp_drops = 0;
  endtask

  task automatic model_accept(input logic [15:0] w);
    exp_an = w[5]; exp_rf = w[4]; exp_stale = 1'b0; exp_toggle = 1'b0;
    if (w[2] === exp_link) exp_run = 0;
    else begin
      exp_run++;
      if (exp_run >= DEB) begin
        exp_toggle = 1'b1;
        if (exp_link) exp_drops = (exp_drops >= 255) ? 255 : exp_drops + 1;
        exp_link = ~exp_link;
        exp_run = 0;
      end
    end
  endtask

  // Waits for poll_req, answers after 'delay' cycles; returns one cycle after rd_valid.
  task automatic serve_poll(input logic [15:0] data, input int delay, input bit noise, output bit seen);
    int n = 0;
    seen = 1'b0;
    while (poll_req !== 1'b1 && n < 200) begin
      rd_valid = noise && ($urandom_range(0, 3) == 0);
      rd_data  = 16'($urandom);
      @(negedge CLK); n++;
    end
    rd_valid = 1'b0;
    if (poll_req === 1'b1) begin
      repeat (delay) begin rd_data = 16'($urandom); @(negedge CLK); end
      rd_data = data; rd_valid = 1'b1;
      @(negedge CLK);
      rd_valid = 1'b0; rd_data = 16'($urandom);
      seen = 1'b1;
    end
  endtask

  task automatic wait_timeout(output int high);
    int n = 0;
    high = 0;
    while (poll_req !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
    while (poll_req === 1'b1 && high < 100) begin high++; @(negedge CLK); end
  endtask

  task automatic test_reset();
    int highs = 0;
    RST = 1'b1; mdio_ready = 1'b0; rd_valid = 1'b0;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({poll_req, link_up, an_done, remote_fault, link_change, stale, drop_count} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b expected all zero",
               {poll_req, link_up, an_done, remote_fault, link_change, stale, drop_count});
    end
    RST = 1'b0;
    model_reset();
    for (int i = 0; i < 5000; i++) begin
      rd_valid = ($urandom_range(0, 9) == 0); rd_data = 16'($urandom);
      @(negedge CLK);
      if (poll_req !== 1'b0 || link_up !== 1'b0 || an_done !== 1'b0) highs++;
    end
    rd_valid = 1'b0;
    n_checks++;
    if (highs != 0) begin n_fail++; $display("FAIL setup_holdoff active_cycles=%0d expected 0", highs); end
  endtask

  task automatic test_setup_release();
    int cyc = 0;
    mdio_ready = 1'b1;
    do begin @(negedge CLK); cyc++; end while (poll_req !== 1'b1 && cyc < 100);
    n_checks++;
    if (cyc != 17) begin n_fail++; $display("FAIL first_poll_latency got %0d expected 17", cyc); end
  endtask

  task automatic test_link_up();
    bit seen;
    int p0 = pulse_cnt;
    for (int k = 0; k < 3; k++) begin
      serve_poll(16'h0024, $urandom_range(0, 6), 1'b0, seen);
      n_checks++;
      if (!seen) begin n_fail++; $display("FAIL linkup_poll%0d no poll_req", k); end
      model_accept(16'h0024);
      n_checks++;
      if (link_up !== 1'b0 || link_change !== 1'b0) begin
        n_fail++; $display("FAIL linkup_early%0d link_up=%b link_change=%b expected 0 0", k, link_up, link_change);
      end
      @(negedge CLK);
      n_checks++;
      if ({link_up, link_change, an_done, remote_fault} !== {exp_link, exp_toggle, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL linkup_eval%0d got %b expected %b", k, {link_up, link_change, an_done, remote_fault},
                 {exp_link, exp_toggle, 1'b1, 1'b0});
      end
    end
    @(negedge CLK);
    n_checks++;
    if (link_change !== 1'b0 || drop_count !== 8'd0 || pulse_cnt - p0 != 1) begin
      n_fail++;
      $display("FAIL linkup_pulse link_change=%b drop=%0d pulses=%0d expected 0 0 1", link_change, drop_count, pulse_cnt - p0);
    end
  endtask

  task automatic test_glitch();
    bit seen;
    logic [15:0] words [5] = '{16'h0020, 16'h0020, 16'h0024, 16'h0020, 16'h0020};
    int p0 = pulse_cnt;
    foreach (words[k]) begin
      serve_poll(words[k], $urandom_range(0, 6), 1'b1, seen);
      model_accept(words[k]);
      @(negedge CLK);
      n_checks++;
      if (!seen || link_up !== 1'b1 || link_up !== exp_link) begin
        n_fail++; $display("FAIL glitch%0d link_up=%b expected 1 (seen=%0d)", k, link_up, seen);
      end
    end
    @(negedge CLK);
    n_checks++;
    if (pulse_cnt != p0) begin n_fail++; $display("FAIL glitch_pulses got %0d expected 0", pulse_cnt - p0); end
  endtask

  task automatic test_timeout();
    int high;
    bit seen;
    wait_timeout(high);
    exp_stale = 1'b1;
    n_checks++;
    if (high != 8 || stale !== 1'b1) begin n_fail++; $display("FAIL timeout high=%0d stale=%b expected 8 1", high, stale); end
    serve_poll(16'h0004, $urandom_range(0, 6), 1'b0, seen);
    model_accept(16'h0004);
    @(negedge CLK);
    n_checks++;
    if (!seen || stale !== 1'b0 || an_done !== 1'b0 || link_up !== exp_link) begin
      n_fail++; $display("FAIL stale_clear stale=%b an_done=%b link_up=%b expected 0 0 %b", stale, an_done, link_up, exp_link);
    end
    serve_poll(16'h0024, 7, 1'b0, seen);
    model_accept(16'h0024);
    n_checks++;
    if (!seen || stale !== 1'b0 || poll_req !== 1'b0) begin
      n_fail++; $display("FAIL coincident_timeout stale=%b poll_req=%b expected 0 0", stale, poll_req);
    end
    @(negedge CLK);
    n_checks++;
    if (stale !== 1'b0 || an_done !== 1'b1) begin
      n_fail++; $display("FAIL coincident_accept stale=%b an_done=%b expected 0 1", stale, an_done);
    end
  endtask

  task automatic test_random();
    bit seen;
    int high;
    logic [15:0] w;
    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 9) == 0) begin
        wait_timeout(high);
        exp_stale = 1'b1;
        n_checks++;
        if (high != 8 || stale !== 1'b1) begin n_fail++; $display("FAIL rand_timeout%0d high=%0d stale=%b", it, high, stale); end
      end else begin
        w = 16'($urandom);
        w[2] = ($urandom_range(0, 9) < 7) ? ~exp_link : exp_link;
        serve_poll(w, $urandom_range(0, 7), 1'b1, seen);
        model_accept(w);
        n_checks++;
        if (!seen || link_change !== 1'b0) begin n_fail++; $display("FAIL rand_early%0d seen=%0d link_change=%b", it, seen, link_change); end
        @(negedge CLK);
        n_checks++;
        if ({link_up, an_done, remote_fault, stale, link_change, drop_count} !==
            {exp_link, exp_an, exp_rf, exp_stale, exp_toggle, 8'(exp_drops)}) begin
          n_fail++;
          $display("FAIL rand_eval%0d got %b expected %b", it, {link_up, an_done, remote_fault, stale, link_change, drop_count},
                   {exp_link, exp_an, exp_rf, exp_stale, exp_toggle, 8'(exp_drops)});
        end
      end
    end
  endtask

  task automatic test_drop_saturation();
    bit seen;
    logic was;
    logic [15:0] w;
    int falls = 0;
    int guard = 0;
    while (falls < 260 && guard < 2000) begin
      w = exp_link ? 16'h0020 : 16'h0024;
      serve_poll(w, 0, 1'b0, seen);
      was = exp_link;
      model_accept(w);
      if (exp_toggle && was) falls++;
      guard++;
      @(negedge CLK);
      n_checks++;
      if (!seen || link_up !== exp_link) begin
        n_fail++; $display("FAIL drop_link%0d link_up=%b expected %b seen=%0d", guard, link_up, exp_link, seen);
        break;
      end
    end
    n_checks++;
    if (drop_count !== 8'hFF || drop_count !== 8'(exp_drops)) begin
      n_fail++; $display("FAIL drop_saturate got %0d expected 255 after %0d falls", drop_count, falls);
    end
  endtask

  task automatic test_ready_loss();
    bit seen;
    int n = 0;
    int highs = 0;
    int cyc = 0;
    while (exp_link !== 1'b1 && n < 10) begin
      serve_poll(16'h0024, 1, 1'b0, seen);
      model_accept(16'h0024);
      @(negedge CLK); n++;
    end
    n = 0;
    while (poll_req !== 1'b1 && n < 200) begin @(negedge CLK); n++; end
    mdio_ready = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (poll_req !== 1'b0 || link_up !== 1'b1) begin
      n_fail++; $display("FAIL ready_loss poll_req=%b link_up=%b expected 0 1", poll_req, link_up);
    end
    repeat (40) begin @(negedge CLK); if (poll_req !== 1'b0 || link_up !== 1'b1) highs++; end
    n_checks++;
    if (highs != 0) begin n_fail++; $display("FAIL ready_hold bad_cycles=%0d expected 0", highs); end
    mdio_ready = 1'b1;
    do begin @(negedge CLK); cyc++; end while (poll_req !== 1'b1 && cyc < 100);
    n_checks++;
    if (cyc != 17) begin n_fail++; $display("FAIL ready_return_latency got %0d expected 17", cyc); end
  endtask

  task automatic test_reset_mid_req();
    int cyc = 0;
    RST = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({poll_req, link_up, an_done, remote_fault, link_change, stale, drop_count} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid_req got %b expected all zero",
               {poll_req, link_up, an_done, remote_fault, link_change, stale, drop_count});
    end
    RST = 1'b0;
    model_reset();
    do begin @(negedge CLK); cyc++; end while (poll_req !== 1'b1 && cyc < 100);
    n_checks++;
    if (cyc != 17) begin n_fail++; $display("FAIL post_reset_latency got %0d expected 17", cyc); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_setup_release();
    test_link_up();
    test_glitch();
    test_timeout();
    test_random();
    test_drop_saturation();
    test_ready_loss();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
